grain128_ctrl: RTL and testbench
================================

Name: grain128_ctrl

Overview:
Sequencer that wraps one grain128 core. It latches a key/IV job, resets the core and waits for initialisation to finish. It then drives `gen` to pull keystream bits, packs them into words and delivers them over a valid/ready stream with backpressure. It sits between the host/bus side and the grain128 core and owns all of the core's control pins.

Parameters:
- WORD_W, 32: keystream word width (bits packed per output word).
- NW_W, 8: width of the word-count field (max 255 words per job).
- RST_CYCLES, 2: number of cycles `core_rst` is held high per job.
- INIT_TIMEOUT, 1024: cycles allowed for core `rdy` to rise after core reset before error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request; accepted only when busy=0.
- key  in  128  key; sampled on the accepted start.
- iv  in  96  IV; sampled on the accepted start.
- nwords  in  NW_W  number of WORD_W words to produce.
- busy  out  1  high from the accepted start until the done/err cycle, inclusive.
- done  out  1  one-cycle pulse: job finished, last word accepted.
- err  out  1  one-cycle pulse: init timeout.
- ks_data  out  WORD_W  keystream word.
- ks_valid  out  1  ks_data valid.
- ks_ready  in  1  downstream accepts the word.
- ks_last  out  1  marks the final word of a job; valid only with ks_valid.
- tag_out  out  32  core `tag`, captured in the done cycle.
- core_rst  out  1  core reset (active-high).
- core_key  out  128  latched key to the core.
- core_iv  out  96  latched IV to the core.
- core_gen  out  1  core generate enable.
- core_rdy  in  1  core ready (init complete).
- core_z  in  1  core keystream bit.
- core_tag  in  32  core tag.

Behaviour:
- Reset (rst=0, async) forces:
  - all outputs 0; state IDLE; bit and word counters 0;
  - core_key and core_iv registers 0.
- Core contract: while core_gen=1 and core_rdy=1, core_z is a fresh bit every clock and is consumed on that edge.
- FSM states: IDLE, CRST, INIT, STREAM, FLUSH, FIN.
- IDLE:
  - start=1 latches key, iv and nwords, and sets busy.
  - nwords=0 -> FIN directly; the core is untouched; done pulses the next cycle.
  - otherwise -> CRST.
- CRST: core_rst=1 for exactly RST_CYCLES cycles, then -> INIT with the timeout counter cleared.
- INIT:
  - core_rdy=1 -> STREAM.
  - timeout counter reaches INIT_TIMEOUT-1 with rdy still 0 -> err pulse, busy cleared, -> IDLE.
- STREAM, collector:
  - Each consumed z shifts into the collector LSB: col = {col[WORD_W-2:0], z}. The first bit ends in the MSB.
  - After WORD_W bits the collector is full.
  - A full collector transfers to the output register when the output is empty or being accepted in the same cycle (out_free = !ks_valid || ks_ready).
- STREAM, core_gen:
  - core_gen = STREAM && bits_left>0 && (!col_full || out_free).
  - This is a combinational path from ks_ready; it is allowed and must be the only such path.
  - Gapless rate with ks_ready held at 1: 1 bit/clk, so one word per WORD_W cycles.
- STREAM exit: after the last bit is collected -> FLUSH, and core_gen is 0 from the next cycle.
- Output register:
  - ks_valid rises the cycle after transfer.
  - ks_data and ks_last are held stable while ks_valid=1 and ks_ready=0.
  - ks_last=1 only on word number nwords.
- FLUSH: waits until the last word is accepted, then -> FIN.
- FIN: done=1 for one cycle; tag_out <= core_tag; busy cleared; -> IDLE.
- start while busy=1 is ignored; it is neither queued nor flagged.
- core_rdy dropping during STREAM: core_gen stays asserted but no bit is consumed. The collector holds, with no error.
- core_key and core_iv remain stable for the whole job.
- Reset asserted mid-job aborts the job: no done, no partial word is emitted, and the job cannot be resumed.

Decomposition:
- Package grain128_pkg holds:
  - KEY_W=128, IV_W=96, TAG_W=32;
  - the FSM state enum;
  - a struct for the latched job {key, iv, nwords}.
- One sub-module, grain128_ks_packer: collector, output register, valid/ready logic and word counting. It exposes a take/full interface to the FSM.
- The FSM, timers and core pins stay in grain128_ctrl.

Test Plan:
- Basic job:
  - Stimulus: key=0123456789abcdef123456789abcdef0, iv=0123456789abcdef12345678, nwords=4, ks_ready=1, behavioural core model (rdy 10 cycles after rst).
  - Required: core_rst high exactly 2 cycles; core_gen high exactly 128 cycles.
  - Required: 4 words equal to the model bitstream, MSB-first; ks_last on word 4 only.
  - Required: done 1 cycle after the last handshake; tag_out equals the model tag.
- Backpressure:
  - Stimulus: nwords=3; ks_ready=0 for 50 cycles after the first ks_valid.
  - Required: core_gen drops after the second word is collected; ks_data is held stable.
  - Required: no bit is lost or duplicated; total core_gen cycles = 96.
- Init timeout: the model never raises rdy -> err pulses at INIT_TIMEOUT cycles after CRST exit; busy falls; ks_valid is never asserted.
- nwords=0 -> done the cycle after start; core_rst and core_gen are never asserted.
- Start while busy:
  - Stimulus: a second start with a different key during STREAM.
  - Required: it is ignored; core_key is unchanged; exactly nwords words are produced.
- Reset mid-job:
  - Stimulus: rst=0 for 1 cycle mid-STREAM.
  - Required: all outputs are 0 immediately (async).
  - Required: a new start then runs a clean job with correct words.

Source files
------------

// File: rtl/grain128_pkg.sv
// grain128_pkg: shared widths, FSM states and the latched job bundle
// for the grain128 sequencer.
package grain128_pkg;

  localparam int KEY_W    = 128;
  localparam int IV_W     = 96;
  localparam int TAG_W    = 32;
  localparam int JOB_NW_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_INIT,
    S_STREAM,
    S_FLUSH,
    S_FIN
  } state_e;

  typedef struct packed {
    logic [KEY_W-1:0]    key;
    logic [IV_W-1:0]     iv;
    logic [JOB_NW_W-1:0] nwords;
  } job_t;

endpackage

// File: rtl/grain128_ks_packer.sv
// grain128_ks_packer: packs keystream bits into words and presents them
// on a valid/ready stream, counting words against the job length.
import grain128_pkg::*;

module grain128_ks_packer #(
  parameter int WORD_W = 32,
  parameter int NW_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic [NW_W-1:0]   nwords_i,
  input  logic              take_i,
  input  logic              z_i,
  input  logic              ks_ready_i,
  output logic              more_o,
  output logic              full_o,
  output logic              free_o,
  output logic              last_acc_o,
  output logic [WORD_W-1:0] ks_data_o,
  output logic              ks_valid_o,
  output logic              ks_last_o
);

  localparam int BC_W = $clog2(WORD_W + 1);
  localparam int CW   = NW_W + 1;

  logic [WORD_W-1:0] col_q;
  logic [BC_W-1:0]   bcnt_q;
  logic [CW-1:0]     wcnt_q;
  logic              xfer;

  assign full_o     = bcnt_q == BC_W'(WORD_W);
  assign free_o     = !ks_valid_o || ks_ready_i;
  assign xfer       = full_o && free_o;
  assign last_acc_o = ks_valid_o && ks_ready_i && ks_last_o;

  // bits remain while words handed over plus a full collector fall short
  assign more_o = (wcnt_q + CW'(full_o)) < {1'b0, nwords_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q      <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      ks_data_o  <= '0;
      ks_valid_o <= 1'b0;
      ks_last_o  <= 1'b0;
    end else if (clr_i) begin
      col_q      <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      ks_data_o  <= '0;
      ks_valid_o <= 1'b0;
      ks_last_o  <= 1'b0;
    end else begin
      if (take_i) begin
        col_q <= {col_q[WORD_W-2:0], z_i};
      end
      if (xfer) begin
        bcnt_q <= take_i ? BC_W'(1) : '0;
      end else if (take_i) begin
        bcnt_q <= bcnt_q + BC_W'(1);
      end
      if (xfer) begin
        ks_data_o  <= col_q;
        ks_valid_o <= 1'b1;
        ks_last_o  <= (wcnt_q + CW'(1)) == {1'b0, nwords_i};
        wcnt_q     <= wcnt_q + CW'(1);
      end else if (ks_valid_o && ks_ready_i) begin
        ks_valid_o <= 1'b0;
        ks_last_o  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/grain128_ctrl.sv
// grain128_ctrl: job sequencer around one grain128 core. Latches key/IV,
// resets and initialises the core, then streams packed keystream words.
import grain128_pkg::*;

module grain128_ctrl #(
  parameter int WORD_W       = 32,
  parameter int NW_W         = 8,
  parameter int RST_CYCLES   = 2,
  parameter int INIT_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  key,
  input  logic [IV_W-1:0]   iv,
  input  logic [NW_W-1:0]   nwords,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] ks_data,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic              ks_last,
  output logic [TAG_W-1:0]  tag_out,
  output logic              core_rst,
  output logic [KEY_W-1:0]  core_key,
  output logic [IV_W-1:0]   core_iv,
  output logic              core_gen,
  input  logic              core_rdy,
  input  logic              core_z,
  input  logic [TAG_W-1:0]  core_tag
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int TC_W = $clog2(INIT_TIMEOUT + 1);

  state_e           state_q;
  job_t             job_q;
  job_t             job_d;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             crst_q;
  logic [TAG_W-1:0] tag_q;
  logic [RC_W-1:0]  rcnt_q;
  logic [TC_W-1:0]  tcnt_q;
  logic             accept;
  logic             zero_job;
  logic             take;
  logic             more;
  logic             full;
  logic             free;
  logic             last_acc;

  assign job_d    = {key, iv, JOB_NW_W'(nwords)};
  assign accept   = (state_q == S_IDLE) && start && !busy_q;
  assign zero_job = nwords == '0;

  // ks_ready reaches core_gen through free: the only comb input path
  assign core_gen = (state_q == S_STREAM) && more && (!full || free);
  assign take     = core_gen && core_rdy;

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tag_out  = tag_q;
  assign core_rst = crst_q;
  assign core_key = job_q.key;
  assign core_iv  = job_q.iv;

  grain128_ks_packer #(
    .WORD_W (WORD_W),
    .NW_W   (JOB_NW_W)
  ) u_pack (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (accept),
    .nwords_i   (job_q.nwords),
    .take_i     (take),
    .z_i        (core_z),
    .ks_ready_i (ks_ready),
    .more_o     (more),
    .full_o     (full),
    .free_o     (free),
    .last_acc_o (last_acc),
    .ks_data_o  (ks_data),
    .ks_valid_o (ks_valid),
    .ks_last_o  (ks_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      job_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b0;
      tag_q   <= '0;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= accept;
          if (accept) begin
            job_q <= job_d;
            if (zero_job) begin
              done_q  <= 1'b1;
              tag_q   <= core_tag;
              state_q <= S_FIN;
            end else begin
              crst_q  <= 1'b1;
              rcnt_q  <= '0;
              state_q <= S_CRST;
            end
          end
        end
        S_CRST: begin
          rcnt_q <= rcnt_q + RC_W'(1);
          if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
            crst_q  <= 1'b0;
            tcnt_q  <= '0;
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          tcnt_q <= tcnt_q + TC_W'(1);
          if (core_rdy) begin
            state_q <= S_STREAM;
          end else if (tcnt_q == TC_W'(INIT_TIMEOUT - 1)) begin
            // busy drops one cycle later so it covers the err cycle
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_STREAM: begin
          if (!more) begin
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (last_acc) begin
            done_q  <= 1'b1;
            tag_q   <= core_tag;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grain128_ctrl.sv
// tb_grain128_ctrl: directed bench with a behavioural core and a
// word-level scoreboard checked every cycle.
module tb_grain128_ctrl;

  localparam int TO = 1024;
  localparam logic [127:0] K1  = 128'h0123456789abcdef123456789abcdef0;
  localparam logic [95:0]  IV1 = 96'h0123456789abcdef12345678;
  localparam logic [127:0] K2  = 128'hfedcba98765432100f1e2d3c4b5a6978;
  localparam logic [95:0]  IV2 = 96'hcafef00ddeadbeef00112233;
  localparam logic [127:0] K3  = 128'h5555aaaa5555aaaa0000ffff0000ffff;
  localparam logic [95:0]  IV3 = 96'h111122223333444455556666;
  localparam logic [127:0] K4  = 128'h0f0f0f0fa5a5a5a53c3c3c3c1234abcd;
  localparam logic [95:0]  IV4 = 96'h89abcdef0123456776543210;

  logic         clk = 0;
  logic         rst = 1;
  logic         start = 0;
  logic         ks_ready = 1;
  logic [127:0] key = '0;
  logic [95:0]  iv = '0;
  logic [7:0]   nwords = '0;
  logic         busy, done, err, ks_valid, ks_last;
  logic         core_rst, core_gen, core_rdy, core_z;
  logic [31:0]  ks_data, tag_out, core_tag;
  logic [127:0] core_key;
  logic [95:0]  core_iv;

  int checks = 0;
  int failures = 0;

  grain128_ctrl #(
    .WORD_W(32), .NW_W(8), .RST_CYCLES(2), .INIT_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv),
    .nwords(nwords), .busy(busy), .done(done), .err(err),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .ks_last(ks_last), .tag_out(tag_out), .core_rst(core_rst),
    .core_key(core_key), .core_iv(core_iv), .core_gen(core_gen),
    .core_rdy(core_rdy), .core_z(core_z), .core_tag(core_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // keystream bit i of the model core: key bits MSB first, repeating
  function automatic logic kbit(input logic [127:0] k, input int unsigned i);
    return k[127 - (i % 128)];
  endfunction

  function automatic logic [31:0] exp_word(input logic [127:0] k, input int w);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[31-b] = kbit(k, 32'(32 * w + b));
    return r;
  endfunction

  // behavioural core
  int unsigned zidx;
  int unsigned rdy_cnt;
  bit          never_rdy = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      zidx <= 0;
      rdy_cnt <= 0;
    end else if (core_rst) begin
      zidx <= 0;
      rdy_cnt <= 0;
    end else begin
      if (rdy_cnt < 100) rdy_cnt <= rdy_cnt + 1;
      if (core_gen && core_rdy) zidx <= zidx + 1;
    end
  end

  assign core_rdy = !never_rdy && !core_rst && (rdy_cnt >= 10);
  assign core_z   = kbit(core_key, zidx);
  assign core_tag = core_key[31:0] ^ core_iv[31:0] ^ zidx;

  // scoreboard
  logic [31:0]  exp_q[$];
  logic [31:0]  got_q[$];
  logic [127:0] exp_key;
  logic [95:0]  exp_iv;
  int           exp_n = 0;
  int           cyc = 0;
  int           last_hs = -10;
  int           rst_cyc = 0, gen_cyc = 0, val_cnt = 0;
  int           done_cnt = 0, err_cnt = 0, err_cyc = 0, crst_last = 0;
  bit           live = 0;
  bit           hold = 0;
  logic [32:0]  hold_v = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      live = 0;
      hold = 0;
    end else begin
      if (hold) chk("hold", {ks_valid, ks_last, ks_data}, {1'b1, hold_v});
      hold = ks_valid && !ks_ready;
      hold_v = {ks_last, ks_data};
      if (live) begin
        chk("core_key", core_key, exp_key);
        chk("core_iv", core_iv, exp_iv);
      end
      if (core_rst) begin
        rst_cyc++;
        crst_last = cyc;
      end
      if (core_gen) gen_cyc++;
      if (ks_valid) val_cnt++;
      if (ks_last && !ks_valid) chk("last_wo_valid", ks_last, 0);
      if (ks_valid && ks_ready) begin
        got_q.push_back(ks_data);
        chk("word_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("ks_data", ks_data, exp_q[0]);
          chk("ks_last", ks_last, exp_q.size() == 1);
          void'(exp_q.pop_front());
        end
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_live", live, 1);
        chk("done_left", exp_q.size(), 0);
        chk("done_lat", cyc - last_hs, 1);
        if (exp_n > 0)
          chk("tag_out", tag_out,
              exp_key[31:0] ^ exp_iv[31:0] ^ 32'(exp_n * 32));
        live = 0;
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
        exp_q.delete();
        live = 0;
      end
      if (start && !busy) begin
        exp_key = key;
        exp_iv = iv;
        exp_n = int'(nwords);
        exp_q.delete();
        got_q.delete();
        for (int w = 0; w < exp_n; w++) exp_q.push_back(exp_word(key, w));
        rst_cyc = 0;
        gen_cyc = 0;
        val_cnt = 0;
        live = 1;
        last_hs = cyc;
      end
    end
  end

  task automatic start_job(input logic [127:0] k, input logic [95:0] v,
                           input logic [7:0] n);
    @(posedge clk);
    #1;
    key = k;
    iv = v;
    nwords = n;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic wait_end(input string nm, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = done || err;
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_for(input string nm, input bit gen_sel, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = gen_sel ? core_gen : ks_valid;
    end
    chk(nm, ok, 1);
  endtask

  int d0;

  initial begin
    #2 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {busy, done, err, ks_valid, ks_last, core_rst, core_gen}, 0);
    chk("rst_data", ks_data, 0);
    chk("rst_tag", tag_out, 0);
    chk("rst_key", core_key, 0);
    chk("rst_iv", core_iv, 0);
    rst = 1;

    // basic job
    start_job(K1, IV1, 8'd4);
    wait_end("basic_end", 400);
    @(negedge clk);
    chk("basic_rst_cyc", rst_cyc, 2);
    chk("basic_gen_cyc", gen_cyc, 128);
    chk("basic_words", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("basic_w0", got_q[0], 32'h01234567);
      chk("basic_w3", got_q[3], 32'h9abcdef0);
    end
    chk("basic_tag", tag_out, 32'h88888808);
    chk("basic_done", done_cnt, 1);

    // backpressure
    ks_ready = 0;
    start_job(K2, IV2, 8'd3);
    wait_for("bp_valid", 0, 300);
    repeat (50) @(posedge clk);
    #1;
    chk("bp_gen_stall", gen_cyc, 64);
    chk("bp_gen_low", core_gen, 0);
    ks_ready = 1;
    wait_end("bp_end", 300);
    @(negedge clk);
    chk("bp_gen_cyc", gen_cyc, 96);
    chk("bp_words", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("bp_w0", got_q[0], 32'hfedcba98);
      chk("bp_w2", got_q[2], 32'h0f1e2d3c);
    end

    // init timeout
    never_rdy = 1;
    d0 = err_cnt;
    start_job(K3, IV3, 8'd2);
    wait_end("to_end", TO + 100);
    chk("to_err", err, 1);
    chk("to_busy_err", busy, 1);
    @(negedge clk);
    chk("to_err_pulse", err, 0);
    chk("to_busy_fall", busy, 0);
    chk("to_gap", err_cyc - (crst_last + 1), TO);
    chk("to_err_cnt", err_cnt - d0, 1);
    chk("to_valid", val_cnt, 0);
    chk("to_gen", gen_cyc, 0);
    never_rdy = 0;

    // zero-length job
    d0 = done_cnt;
    start_job(K4, IV4, 8'd0);
    wait_end("zero_end", 10);
    @(negedge clk);
    chk("zero_done", done_cnt - d0, 1);
    chk("zero_rst", rst_cyc, 0);
    chk("zero_gen", gen_cyc, 0);

    // start while busy
    start_job(K4, IV4, 8'd3);
    wait_for("sb_gen", 1, 100);
    @(posedge clk);
    #1;
    key = ~K4;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    wait_end("sb_end", 400);
    @(negedge clk);
    chk("sb_words", got_q.size(), 3);
    chk("sb_key", core_key, K4);

    // reset mid-job
    start_job(K2, IV2, 8'd4);
    wait_for("mr_gen", 1, 100);
    repeat (20) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst = 0;
    #1;
    chk("mr_ctl", {busy, done, err, ks_valid, ks_last, core_rst, core_gen}, 0);
    chk("mr_data", ks_data, 0);
    chk("mr_tag", tag_out, 0);
    chk("mr_key", {core_key, core_iv}, 0);
    @(posedge clk);
    #1;
    rst = 1;
    repeat (5) @(negedge clk);
    chk("mr_no_done", done_cnt, d0);
    start_job(K1, IV1, 8'd2);
    wait_end("mr_end", 300);
    @(negedge clk);
    chk("mr_words", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("mr_w0", got_q[0], 32'h01234567);
      chk("mr_w1", got_q[1], 32'h89abcdef);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
